// File: rtl/fp8_dot_sequencer_if.sv
// Operand stream, external FP8 multiplier/adder hookup and result handshake
// of fp8_dot_sequencer, bundled for connection between the sequencer and its environment.
interface fp8_dot_sequencer_if #(
  parameter int N_MAX = 12
) ();
  localparam int LEN_W = $clog2(N_MAX + 1);

  logic             start96;
  logic [LEN_W-1:0] len96;
  logic             in_valid96;
  logic             in_ready96;
  logic [7:0]       a_in96;
  logic [7:0]       b_in96;
  logic [7:0]       mul_a96;
  logic [7:0]       mul_b96;
  logic [7:0]       mul_res96;
  logic [7:0]       add_a96;
  logic [7:0]       add_b96;
  logic [7:0]       add_res96;
  logic             out_valid96;
  logic             out_ready96;
  logic [7:0]       out_data96;
  logic             busy96;

  modport slave (
    input  start96, len96, in_valid96, a_in96, b_in96, mul_res96, add_res96, out_ready96,
    output in_ready96, mul_a96, mul_b96, add_a96, add_b96, out_valid96, out_data96, busy96
  );

  modport master (
    output start96, len96, in_valid96, a_in96, b_in96, mul_res96, add_res96, out_ready96,
    input  in_ready96, mul_a96, mul_b96, add_a96, add_b96, out_valid96, out_data96, busy96
  );
endinterface

// File: rtl/fp8_dot_sequencer.sv
// Issues A/B operand pairs to an external FP8 multiplier, queues the products and
// folds them serially through an external FP8 adder into a single dot product.
module fp8_dot_sequencer #(
  parameter int N_MAX   = 12,
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 3
) (
  input  logic               clk96,
  input  logic               rst96,
  fp8_dot_sequencer_if.slave bus
);
  localparam int LEN_W  = $clog2(N_MAX + 1);
  localparam int WAIT_W = $clog2(ADD_LAT + 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(N_MAX);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(ADD_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [LEN_W-1:0]    target_q;
  logic [LEN_W-1:0]    acc_cnt_q;
  logic [LEN_W-1:0]    done_cnt_q;
  logic [LEN_W-1:0]    done_cnt_d;
  logic [LEN_W-1:0]    wr_ptr_q;
  logic [LEN_W-1:0]    rd_ptr_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [MUL_LAT:0]    vld_sr_q;
  logic [7:0]          mul_a_q;
  logic [7:0]          mul_b_q;
  logic [7:0]          acc_q;
  logic [7:0]          fifo_q [N_MAX];
  logic                in_ready;
  logic                accept;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [LEN_W-1:0]    len_clip;

  assign in_ready   = (state_q == RUN) && (acc_cnt_q < target_q);
  assign accept     = bus.in_valid96 & in_ready;
  assign fifo_empty = (rd_ptr_q == wr_ptr_q);
  // Bit 0 tracks the operand register; the top bit lines up with mul_res96.
  assign push       = vld_sr_q[MUL_LAT];
  assign pop        = !fifo_empty && (wait_q == WAIT_END);
  assign done_cnt_d = done_cnt_q + LEN_W'(pop);
  assign len_clip   = (bus.len96 > LEN_MAX) ? LEN_MAX : bus.len96;

  assign bus.in_ready96  = in_ready;
  assign bus.mul_a96     = mul_a_q;
  assign bus.mul_b96     = mul_b_q;
  assign bus.add_a96     = acc_q;
  assign bus.add_b96     = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign bus.out_valid96 = out_valid_q;
  assign bus.out_data96  = acc_q;
  assign bus.busy96      = busy_q;

  // Product storage; pointers restart at every job so no wrap is ever needed.
  always_ff @(posedge clk96) begin
    if (push) fifo_q[wr_ptr_q] <= bus.mul_res96;
  end

  always_ff @(posedge clk96) begin
    if (!rst96) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      target_q    <= '0;
      acc_cnt_q   <= '0;
      done_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wait_q      <= '0;
      vld_sr_q    <= '0;
      mul_a_q     <= 8'h00;
      mul_b_q     <= 8'h00;
      acc_q       <= 8'h00;
    end else begin
      mul_a_q  <= accept ? bus.a_in96 : 8'h00;
      mul_b_q  <= accept ? bus.b_in96 : 8'h00;
      vld_sr_q <= {vld_sr_q[MUL_LAT-1:0], accept};
      if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      // Adder operands stay put for ADD_LAT+1 cycles, then the sum is taken.
      if (!fifo_empty) wait_q <= pop ? '0 : wait_q + 1'b1;
      if (pop) begin
        acc_q      <= bus.add_res96;
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        done_cnt_q <= done_cnt_d;
      end

      case (state_q)
        IDLE: begin
          if (bus.start96) begin
            target_q   <= len_clip;
            acc_q      <= 8'h00;
            acc_cnt_q  <= '0;
            done_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b1;
            if (bus.len96 == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (pop && (done_cnt_d == target_q)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid_q && bus.out_ready96) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp8_dot_sequencer.sv
// Directed bench for fp8_dot_sequencer with behavioural E4M3 multiplier/adder
// models (bias 7, latency 3) closing the loop around the sequencer.
module tb_fp8_dot_sequencer;
  localparam int N_MAX = 12;
  localparam int LEN_W = $clog2(N_MAX + 1);

  logic clk96 = 1'b0;
  logic rst96 = 1'b0;
  always #5 clk96 = ~clk96;

  fp8_dot_sequencer_if #(.N_MAX(N_MAX)) bus ();

  fp8_dot_sequencer #(.N_MAX(N_MAX), .MUL_LAT(3), .ADD_LAT(3)) dut (
    .clk96 (clk96),
    .rst96 (rst96),
    .bus   (bus)
  );

  function automatic real pow2(int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_to_real(logic [7:0] x);
    int  e = int'(x[6:3]);
    real m = real'(x[2:0]);
    real v;
    if (e == 0) v = (m / 8.0) * pow2(-6);
    else v = (1.0 + m / 8.0) * pow2(e - 7);
    return x[7] ? -v : v;
  endfunction

  function automatic logic [7:0] real_to_fp8(real v);
    logic s = (v < 0.0);
    real  a = s ? -v : v;
    int   e;
    int   m;
    if (a < pow2(-6)) return {s, 7'd0};
    e = 7;
    while (a >= pow2(e - 6) && e < 15) e++;
    while (a < pow2(e - 7)) e--;
    m = $rtoi((a / pow2(e - 7) - 1.0) * 8.0 + 0.5);
    if (m == 8) begin m = 0; e++; end
    if (e > 15) begin e = 15; m = 6; end
    return {s, 4'(e), 3'(m)};
  endfunction

  function automatic logic [7:0] fp8_mul(logic [7:0] a, logic [7:0] b);
    return real_to_fp8(fp8_to_real(a) * fp8_to_real(b));
  endfunction

  function automatic logic [7:0] fp8_add(logic [7:0] a, logic [7:0] b);
    return real_to_fp8(fp8_to_real(a) + fp8_to_real(b));
  endfunction

  logic [7:0] mul_pipe [3];
  logic [7:0] add_pipe [3];
  always_ff @(posedge clk96) begin
    mul_pipe[0] <= fp8_mul(bus.mul_a96, bus.mul_b96);
    add_pipe[0] <= fp8_add(bus.add_a96, bus.add_b96);
    for (int i = 1; i < 3; i++) begin
      mul_pipe[i] <= mul_pipe[i-1];
      add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign bus.mul_res96 = mul_pipe[2];
  assign bus.add_res96 = add_pipe[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk96);
    #1;
    cyc++;
  endtask

  task automatic start_job(input int len);
    bus.len96   = LEN_W'(len);
    bus.start96 = 1'b1;
    cyc = 0;
    tick();
    bus.start96 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic stable;

    // Reset held with start asserted
    bus.start96 = 1'b1; bus.len96 = 1; bus.in_valid96 = 1'b1;
    bus.a_in96 = 8'h38; bus.b_in96 = 8'h40; bus.out_ready96 = 1'b1;
    rst96 = 1'b0;
    @(posedge clk96); @(posedge clk96); #1;
    chk("rst_in_ready", bus.in_ready96, 0);
    chk("rst_out_valid", bus.out_valid96, 0);
    chk("rst_busy", bus.busy96, 0);
    chk("rst_out_data", bus.out_data96, 8'h00);
    chk("rst_mul_a", bus.mul_a96, 8'h00);
    chk("rst_mul_b", bus.mul_b96, 8'h00);
    chk("rst_add_a", bus.add_a96, 8'h00);
    chk("rst_add_b", bus.add_b96, 8'h00);
    bus.start96 = 1'b0; bus.in_valid96 = 1'b0; rst96 = 1'b1;
    tick();
    chk("rst_no_job", bus.busy96, 0);

    // Single element: 1.0 * 2.0
    start_job(1);
    chk("l1_busy", bus.busy96, 1);
    chk("l1_ready", bus.in_ready96, 1);
    bus.in_valid96 = 1'b1; bus.a_in96 = 8'h38; bus.b_in96 = 8'h40;
    tick();
    bus.in_valid96 = 1'b0;
    chk("l1_mul_a", bus.mul_a96, 8'h38);
    chk("l1_ready_low", bus.in_ready96, 0);
    while (cyc < 9) tick();
    chk("l1_valid_c9", bus.out_valid96, 0);
    tick();
    chk("l1_valid_c10", bus.out_valid96, 1);
    chk("l1_data", bus.out_data96, 8'h40);
    tick();
    chk("l1_idle", bus.busy96, 0);
    chk("l1_valid_drop", bus.out_valid96, 0);

    // Full length, twelve 1.0*1.0 products back-to-back
    bus.in_valid96 = 1'b1; bus.a_in96 = 8'h38; bus.b_in96 = 8'h38;
    start_job(12);
    n = 0;
    while (cyc < 54) begin
      if (bus.in_valid96 && bus.in_ready96) n++;
      if (cyc == 5)  chk("l12_addb_empty", bus.add_b96, 8'h00);
      if (cyc == 6)  chk("l12_addb_head", bus.add_b96, 8'h38);
      if (cyc == 13) chk("l12_ready_drop", bus.in_ready96, 0);
      if (cyc == 13) chk("l12_adda_1", bus.add_a96, 8'h38);
      if (cyc == 14) chk("l12_adda_2", bus.add_a96, 8'h40);
      if (cyc == 18) chk("l12_adda_3", bus.add_a96, 8'h44);
      if (cyc == 53) chk("l12_valid_c53", bus.out_valid96, 0);
      tick();
    end
    bus.in_valid96 = 1'b0;
    chk("l12_accepts", n, 12);
    chk("l12_valid_c54", bus.out_valid96, 1);
    chk("l12_data", bus.out_data96, 8'h54);
    tick();

    // Bubbles, start pulses while busy, output stall
    bus.out_ready96 = 1'b0; bus.a_in96 = 8'h40; bus.b_in96 = 8'h38;
    start_job(4);
    n = 0;
    while (!bus.out_valid96 && cyc < 100) begin
      bus.in_valid96 = cyc[0];
      bus.start96 = (cyc == 3 || cyc == 12);
      bus.len96 = 1;
      if (bus.in_valid96 && bus.in_ready96) n++;
      tick();
    end
    bus.in_valid96 = 1'b0; bus.start96 = 1'b0;
    chk("bub_valid", bus.out_valid96, 1);
    chk("bub_cycle", cyc, 22);
    chk("bub_accepts", n, 4);
    chk("bub_data", bus.out_data96, 8'h50);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.start96 = (i == 2);
      if (!(bus.out_valid96 === 1'b1 && bus.out_data96 === 8'h50)) stable = 1'b0;
      tick();
    end
    bus.start96 = 1'b0;
    chk("bub_stable", stable, 1);
    chk("bub_hold_valid", bus.out_valid96, 1);
    bus.out_ready96 = 1'b1;
    tick();
    chk("bub_idle", bus.busy96, 0);
    chk("bub_valid_drop", bus.out_valid96, 0);

    // Zero length
    start_job(0);
    chk("l0_valid", bus.out_valid96, 1);
    chk("l0_data", bus.out_data96, 8'h00);
    chk("l0_busy", bus.busy96, 1);
    tick();
    chk("l0_idle", bus.busy96, 0);

    // Length above N_MAX clips to 12
    bus.in_valid96 = 1'b1; bus.a_in96 = 8'h38; bus.b_in96 = 8'h38;
    start_job(15);
    n = 0;
    while (cyc < 20) begin
      if (bus.in_valid96 && bus.in_ready96) n++;
      tick();
    end
    bus.in_valid96 = 1'b0;
    chk("l15_accepts", n, 12);
    chk("l15_ready", bus.in_ready96, 0);
    while (!bus.out_valid96 && cyc < 100) tick();
    chk("l15_cycle", cyc, 54);
    chk("l15_data", bus.out_data96, 8'h54);
    tick();

    // Reset after five accepts, then a clean len=2 job of 2.0*2.0
    bus.in_valid96 = 1'b1; bus.a_in96 = 8'h48; bus.b_in96 = 8'h48;
    start_job(12);
    n = 0;
    while (n < 5 && cyc < 50) begin
      if (bus.in_valid96 && bus.in_ready96) n++;
      tick();
    end
    bus.in_valid96 = 1'b0;
    rst96 = 1'b0;
    tick(); tick();
    chk("mid_rst_busy", bus.busy96, 0);
    chk("mid_rst_addb", bus.add_b96, 8'h00);
    chk("mid_rst_data", bus.out_data96, 8'h00);
    rst96 = 1'b1;
    tick();
    bus.in_valid96 = 1'b1; bus.a_in96 = 8'h40; bus.b_in96 = 8'h40;
    start_job(2);
    n = 0;
    while (!bus.out_valid96 && cyc < 100) begin
      if (bus.in_valid96 && bus.in_ready96) n++;
      tick();
    end
    bus.in_valid96 = 1'b0;
    chk("mid_accepts", n, 2);
    chk("mid_cycle", cyc, 14);
    chk("mid_data", bus.out_data96, 8'h50);
    tick();
    chk("mid_idle", bus.busy96, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp8_dot_sequencer.md
# fp8_dot_sequencer

Operand-issue and accumulation controller for the FP8 MAC datapath. It accepts an A/B operand stream over a valid/ready handshake and drives a pipelined FP8 multiplier. It buffers the products and feeds them serially into a pipelined FP8 adder, holding each accumulation until the adder result returns. It then presents the finished dot product on a valid/ready output. The multiplier and adder are external, and operands and results are treated as opaque 8-bit E4M3 words.

## Interface
Parameters:
- N_MAX, 12: maximum vector length; also the product FIFO depth.
- MUL_LAT, 3: multiplier latency in cycles. Operands driven in cycle c produce a valid result in cycle c+MUL_LAT.
- ADD_LAT, 3: adder latency in cycles, same definition as MUL_LAT.

Ports:
- clk96  in  1  clock; all state updates on its rising edge.
- rst96  in  1  reset, synchronous, active-low.
- start96  in  1  starts a job; sampled only in IDLE.
- len96  in  $clog2(N_MAX+1)  vector length, sampled with start96.
- in_valid96  in  1  operand pair valid.
- in_ready96  out  1  operand pair accepted when in_valid96 & in_ready96.
- a_in96, b_in96  in  8  operand pair.
- mul_a96, mul_b96  out  8  multiplier operands (registered).
- mul_res96  in  8  multiplier result.
- add_a96, add_b96  out  8  adder operands: accumulator and FIFO head.
- add_res96  in  8  adder result.
- out_valid96  out  1  dot product valid.
- out_ready96  in  1  consumer accepts the dot product.
- out_data96  out  8  dot product.
- busy96  out  1  high whenever the main state is not IDLE.

## Operation
- Main FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start96=1. On this transition:
  - latch the target length as min(len96, N_MAX);
  - clear the accumulator to 0x00, the accept counter and the done counter.
- IDLE -> DONE when start96=1 and len96=0. out_data96 is 0x00.
- RUN -> DONE when the done counter equals the target length.
- DONE -> IDLE on out_valid96 & out_ready96.
- start96 is ignored outside IDLE.
- in_ready96 = (state==RUN) & (accept count < target).
- On each accept:
  - register a_in96/b_in96 into mul_a96/mul_b96;
  - push a 1 into a MUL_LAT-deep valid shift register.
- Cycles without an accept drive mul_a96/mul_b96 to 0x00 and push a 0.
- When the shift-register output is 1, write mul_res96 into the product FIFO at the end of that cycle. The FIFO cannot overflow because at most target ≤ N_MAX products are written per job.
- Accumulate engine:
  - add_a96 = accumulator register; add_b96 = FIFO head, or 0x00 when the FIFO is empty.
  - While the FIFO is non-empty, a wait counter counts 0..ADD_LAT.
  - At count==ADD_LAT: accumulator <= add_res96, pop the FIFO, done counter +1, wait counter <= 0.
  - Operands are therefore held stable for ADD_LAT+1 cycles per product.
- Accumulation order is strictly serial: ((0x00 + p0) + p1) + ... in accept order.
- out_data96 = accumulator. It is stable while out_valid96=1.
- Reset mid-operation: the FSM goes to IDLE, the FIFO is emptied, the valid shift register is cleared and in-flight products are discarded.

## Timing
- Reset values: in_ready96=0, out_valid96=0, busy96=0, out_data96=0x00, mul_a96=mul_b96=0x00, add_a96=add_b96=0x00.
- Cycle references below take start96 sampled at the end of cycle 0 and operands back-to-back.
- Operand k is accepted at the end of cycle 1+k.
- Product k enters the FIFO at the end of cycle 2+k+MUL_LAT.
- The first accumulation uses cycles 3+MUL_LAT .. 3+MUL_LAT+ADD_LAT.
- Accumulations are then spaced ADD_LAT+1 cycles apart.
- out_valid96 rises in cycle 3+MUL_LAT+(ADD_LAT+1)·len. With defaults: len=1 gives cycle 10; len=12 gives cycle 54.
- in_valid96 bubbles delay the accept index but never reorder the accumulation.
- out_valid96 stays high until the handshake. IDLE is entered in the cycle after the handshake, and a new start96 is accepted there.

## Test plan
Benches use behavioural E4M3 multiplier/adder models (bias 7) with latency 3.
- Reset: hold rst96=0 for 2 cycles with start96=1 -> all outputs at their reset values and no job starts.
- Single-element job: len=1, a=0x38 (1.0), b=0x40 (2.0) -> out_data96=0x40, out_valid96 in cycle 10.
- Full-length job: len=12, all operands 0x38, back-to-back ->
  - in_ready96 drops after 12 accepts;
  - add_b96 changes every 4 cycles;
  - out_data96=0x54 (12.0) in cycle 54.
- Bubbles and stalls: len=4, in_valid96 on every other cycle, operands 0x40×0x38, out_ready96 low for 5 cycles, start96 pulsed while busy ->
  - out_data96=0x50 (8.0), held stable until the handshake;
  - the start96 pulses are ignored.
- Length boundaries:
  - len=0 -> out_valid96=1 with out_data96=0x00 in cycle 1.
  - len=15 -> exactly 12 accepts, then in_ready96=0.
- Reset mid-job: rst96=0 after 5 accepts, then start a len=2 job with 0x40×0x40 twice -> out_data96=0x50 (8.0), with no contamination from the aborted job.
